// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file, bus-side pointer auto-increment,
// and a local synchronous read/write port into the same registers.
module i2c_target_regfile #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         REG_COUNT   = 16,
    parameter int         FILTER_LEN  = 3,
    localparam int        A           = $clog2(REG_COUNT)
) (
    input  logic         io_clock,
    input  logic         io_reset,
    input  logic         io_i2c_scl_read,
    output logic         io_i2c_scl_write,
    input  logic         io_i2c_sda_read,
    output logic         io_i2c_sda_write,
    input  logic [A-1:0] io_reg_addr,
    input  logic [7:0]   io_reg_wdata,
    input  logic         io_reg_we,
    output logic [7:0]   io_reg_rdata,
    output logic         io_busy,
    output logic         io_wr_event,
    output logic [A-1:0] io_wr_index
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WR_ACK, READ, RD_ACK, WAIT_STOP
    } state_t;

    localparam logic [2:0] FLT_LAST = 3'(FILTER_LEN - 1);

    // index 0 = SCL, index 1 = SDA
    logic [1:0] sync1, sync2, filt, filt_q;
    logic [2:0] fcnt [2];

    always_ff @(posedge io_clock or negedge io_reset) begin
        if (!io_reset) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            filt    <= 2'b11;
            filt_q  <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync1  <= {io_i2c_sda_read, io_i2c_scl_read};
            sync2  <= sync1;
            filt_q <= filt;
            // a line only flips after FILTER_LEN consecutive differing samples
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FLT_LAST) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 3'd1;
                end
            end
        end
    end

    logic scl_rise, scl_fall, scl_high, start_c, stop_c;
    assign scl_rise = filt[0] & ~filt_q[0];
    assign scl_fall = ~filt[0] & filt_q[0];
    assign scl_high = filt[0] & filt_q[0];
    assign start_c  = scl_high & ~filt[1] & filt_q[1];
    assign stop_c   = scl_high & filt[1] & ~filt_q[1];

    state_t       state, state_nx;
    logic [7:0]   shift, shift_nx;
    logic [2:0]   cnt, cnt_nx;
    logic [A-1:0] ptr, ptr_nx;
    logic         drive, drive_nx;
    logic         busy, busy_nx;
    logic         rw, rw_nx;
    logic         acked, acked_nx;
    logic         bus_we;
    logic [7:0]   rx_byte;
    logic [7:0]   regs [REG_COUNT];

    assign rx_byte = {shift[6:0], filt[1]};

    always_comb begin
        state_nx = state;
        shift_nx = shift;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        drive_nx = drive;
        busy_nx  = busy;
        rw_nx    = rw;
        acked_nx = acked;
        bus_we   = 1'b0;
        if (stop_c) begin
            state_nx = IDLE;
            drive_nx = 1'b0;
            busy_nx  = 1'b0;
            cnt_nx   = '0;
        end else if (start_c) begin
            state_nx = ADDR;
            drive_nx = 1'b0;
            cnt_nx   = '0;
        end else begin
            case (state)
                ADDR, PTR, WRITE: begin
                    if (scl_rise) begin
                        shift_nx = rx_byte;
                        cnt_nx   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            cnt_nx = '0;
                            if (state == ADDR) begin
                                if (rx_byte[7:1] == TARGET_ADDR) begin
                                    state_nx = ADDR_ACK;
                                    rw_nx    = rx_byte[0];
                                    busy_nx  = 1'b1;
                                end else begin
                                    state_nx = IDLE;
                                    busy_nx  = 1'b0;
                                end
                            end else if (state == PTR) begin
                                ptr_nx   = rx_byte[A-1:0];
                                state_nx = PTR_ACK;
                            end else begin
                                bus_we   = 1'b1;
                                ptr_nx   = ptr + A'(1);
                                state_nx = WR_ACK;
                            end
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WR_ACK: begin
                    // first fall pulls SDA low, second fall releases it
                    if (scl_fall) begin
                        if (!drive) begin
                            drive_nx = 1'b1;
                        end else begin
                            drive_nx = 1'b0;
                            cnt_nx   = '0;
                            if (state == ADDR_ACK && rw) begin
                                state_nx = READ;
                                shift_nx = {regs[ptr][6:0], 1'b1};
                                drive_nx = ~regs[ptr][7];
                            end else if (state == ADDR_ACK) begin
                                state_nx = PTR;
                            end else begin
                                state_nx = WRITE;
                            end
                        end
                    end
                end
                READ: begin
                    if (scl_fall) begin
                        if (cnt == 3'd7) begin
                            drive_nx = 1'b0;
                            cnt_nx   = '0;
                            acked_nx = 1'b0;
                            state_nx = RD_ACK;
                        end else begin
                            drive_nx = ~shift[7];
                            shift_nx = {shift[6:0], 1'b1};
                            cnt_nx   = cnt + 3'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!filt[1]) begin
                            acked_nx = 1'b1;
                            ptr_nx   = ptr + A'(1);
                        end else begin
                            state_nx = WAIT_STOP;
                        end
                    end else if (scl_fall && acked) begin
                        state_nx = READ;
                        cnt_nx   = '0;
                        shift_nx = {regs[ptr][6:0], 1'b1};
                        drive_nx = ~regs[ptr][7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge io_clock or negedge io_reset) begin
        if (!io_reset) begin
            state <= IDLE;
            shift <= '0;
            cnt   <= '0;
            ptr   <= '0;
            drive <= 1'b0;
            busy  <= 1'b0;
            rw    <= 1'b0;
            acked <= 1'b0;
        end else begin
            state <= state_nx;
            shift <= shift_nx;
            cnt   <= cnt_nx;
            ptr   <= ptr_nx;
            drive <= drive_nx;
            busy  <= busy_nx;
            rw    <= rw_nx;
            acked <= acked_nx;
        end
    end

    // local write is applied last so it wins a same-index collision
    always_ff @(posedge io_clock or negedge io_reset) begin
        if (!io_reset) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
            io_reg_rdata <= '0;
            io_wr_event  <= 1'b0;
            io_wr_index  <= '0;
        end else begin
            io_reg_rdata <= regs[io_reg_addr];
            io_wr_event  <= bus_we;
            if (bus_we) begin
                regs[ptr]   <= rx_byte;
                io_wr_index <= ptr;
            end
            if (io_reg_we) regs[io_reg_addr] <= io_reg_wdata;
        end
    end

    assign io_i2c_sda_write = drive;
    assign io_i2c_scl_write = 1'b0;
    assign io_busy          = busy;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-level I2C controller, wired-AND bus and a
// transaction-level model of registers, pointer, busy and write events.
module tb_i2c_target_regfile;
    localparam int RC = 16;
    localparam int AW = 4;
    localparam int Q  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scl_c = 1'b1;
    logic          sda_c = 1'b1;
    logic          scl_w, sda_w, scl_line, sda_line;
    logic [AW-1:0] reg_addr = '0;
    logic [7:0]    reg_wdata = '0;
    logic          reg_we = 1'b0;
    logic [7:0]    reg_rdata;
    logic          busy, wr_event;
    logic [AW-1:0] wr_index;

    assign scl_line = scl_c & ~scl_w;
    assign sda_line = sda_c & ~sda_w;
    always #5 clk = ~clk;

    i2c_target_regfile dut (
        .io_clock(clk), .io_reset(rst_n),
        .io_i2c_scl_read(scl_line), .io_i2c_scl_write(scl_w),
        .io_i2c_sda_read(sda_line), .io_i2c_sda_write(sda_w),
        .io_reg_addr(reg_addr), .io_reg_wdata(reg_wdata), .io_reg_we(reg_we),
        .io_reg_rdata(reg_rdata), .io_busy(busy),
        .io_wr_event(wr_event), .io_wr_index(wr_index)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] mdl [RC];
    int         mptr = 0;
    bit         mbusy = 0;
    int         exp_q[$];
    int         ev_log[$];
    bit         chk_en = 0, chk_busy = 0, exp_drive = 0;
    bit [7:0]   txq[$];

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("scl_write", scl_w, 0);
            if (chk_en)   check("sda_write", sda_w, exp_drive);
            if (chk_busy) check("busy", busy, mbusy);
            if (wr_event) begin
                ev_log.push_back(int'(wr_index));
                if (exp_q.size() == 0) check("wr_event_spurious", wr_event, 0);
                else check("wr_index", wr_index, exp_q.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic start();
        if (!scl_c) begin
            wait_cyc(Q); sda_c = 1'b1;
            wait_cyc(Q); scl_c = 1'b1;
        end
        wait_cyc(Q); sda_c = 1'b0;
        wait_cyc(Q); scl_c = 1'b0;
    endtask

    task automatic stop();
        wait_cyc(Q); sda_c = 1'b0;
        wait_cyc(Q); scl_c = 1'b1;
        wait_cyc(Q); sda_c = 1'b1;
        wait_cyc(2 * Q);
        mbusy = 0;
    endtask

    // one SCL clock; target drive is checked for the whole high phase
    task automatic bit_clk(input bit v, input bit ed);
        wait_cyc(Q); sda_c = v;
        wait_cyc(Q); scl_c = 1'b1;
        wait_cyc(2); exp_drive = ed; chk_en = 1;
        wait_cyc(2 * Q - 4); chk_en = 0;
        wait_cyc(2); scl_c = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ack);
        for (int i = 7; i >= 0; i--) bit_clk(b[i], 1'b0);
        chk_busy = 1;
        bit_clk(1'b1, ack);
        chk_busy = 0;
    endtask

    task automatic local_wr(input int a, input logic [7:0] d);
        reg_addr = AW'(a); reg_wdata = d; reg_we = 1'b1;
        wait_cyc(1);
        reg_we = 1'b0;
        mdl[a] = d;
    endtask

    task automatic local_chk(input int a);
        reg_addr = AW'(a);
        wait_cyc(2);
        check("reg_rdata", reg_rdata, mdl[a]);
    endtask

    task automatic read_byte(input logic [7:0] e, input bit ack, input bit lw, input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            bit_clk(1'b1, ~e[i]);
            if (i == 7 && lw) local_wr(mptr, v);
        end
        bit_clk(ack ? 1'b0 : 1'b1, 1'b0);
    endtask

    // txq holds [pointer, data...]
    task automatic wr_xfer(input logic [6:0] a7, input bit do_stop);
        bit hit;
        hit = (a7 == 7'h42);
        start();
        mbusy = hit;
        send_byte({a7, 1'b0}, hit);
        for (int i = 0; i < txq.size(); i++) begin
            if (!hit) begin
                send_byte(txq[i], 1'b0);
            end else if (i == 0) begin
                mptr = int'(txq[0]) % RC;
                send_byte(txq[0], 1'b1);
            end else begin
                exp_q.push_back(mptr);
                mdl[mptr] = txq[i];
                mptr = (mptr + 1) % RC;
                send_byte(txq[i], 1'b1);
            end
        end
        if (do_stop) stop();
    endtask

    task automatic rd_xfer(input int n);
        logic [7:0] e, v;
        bit lw;
        start();
        mbusy = 1;
        send_byte(8'h85, 1'b1);
        for (int i = 0; i < n; i++) begin
            e  = mdl[mptr];
            lw = ($urandom_range(0, 3) == 0);
            v  = 8'($urandom);
            read_byte(e, i < n - 1, lw, v);
            if (i < n - 1) mptr = (mptr + 1) % RC;
        end
        stop();
    endtask

    task automatic abort_xfer(input logic [7:0] p, input int k);
        start();
        mbusy = 1;
        send_byte(8'h84, 1'b1);
        mptr = int'(p) % RC;
        send_byte(p, 1'b1);
        for (int i = 0; i < k; i++) bit_clk(1'($urandom), 1'b0);
        stop();
    endtask

    task automatic dump_regs();
        for (int i = 0; i < RC; i++) local_chk(i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        int n0;
        for (int i = 0; i < RC; i++) mdl[i] = 8'h00;
        wait_cyc(3);
        check("rst_sda_write", sda_w, 0);
        check("rst_scl_write", scl_w, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_event", wr_event, 0);
        check("rst_wr_index", wr_index, 0);
        check("rst_rdata", reg_rdata, 0);
        rst_n = 1'b1;
        wait_cyc(4);

        // 1: two data bytes from pointer 3
        ev_log.delete();
        txq = {8'h03, 8'hA5, 8'h5A};
        wr_xfer(7'h42, 1);
        check("t1_ev_count", ev_log.size(), 2);
        if (ev_log.size() == 2) begin
            check("t1_ev0", ev_log[0], 3);
            check("t1_ev1", ev_log[1], 4);
        end
        check("t1_busy", busy, 0);
        reg_addr = 4'd3; wait_cyc(2); check("t1_reg3", reg_rdata, 8'hA5);
        reg_addr = 4'd4; wait_cyc(2); check("t1_reg4", reg_rdata, 8'h5A);

        // 2: pointer wrap
        txq = {8'h0F, 8'h11, 8'h22};
        wr_xfer(7'h42, 1);
        reg_addr = 4'd15; wait_cyc(2); check("t2_reg15", reg_rdata, 8'h11);
        reg_addr = 4'd0;  wait_cyc(2); check("t2_reg0", reg_rdata, 8'h22);

        // 3: local write, set pointer, repeated START, read two bytes
        local_wr(7, 8'hC3);
        txq = {8'h07};
        wr_xfer(7'h42, 0);
        start();
        mbusy = 1;
        send_byte(8'h85, 1'b1);
        read_byte(8'hC3, 1'b1, 1'b0, 8'h00);
        mptr = 8;
        read_byte(mdl[8], 1'b0, 1'b0, 8'h00);
        wait_cyc(4);
        check("t3_released", sda_w, 0);
        stop();

        // 4: foreign address
        n0 = ev_log.size();
        txq = {8'h01, 8'h77};
        wr_xfer(7'h48, 1);
        check("t4_busy", busy, 0);
        check("t4_no_event", ev_log.size(), n0);
        dump_regs();

        // 5: STOP mid-byte, then a normal transfer
        n0 = ev_log.size();
        abort_xfer(8'h06, 4);
        check("t5_busy", busy, 0);
        check("t5_no_event", ev_log.size(), n0);
        local_chk(6);
        txq = {8'h06, 8'h9C};
        wr_xfer(7'h42, 1);
        reg_addr = 4'd6; wait_cyc(2); check("t5_reg6", reg_rdata, 8'h9C);

        // 6: reset while the target drives a data 0
        local_wr(9, 8'h12);
        txq = {8'h09};
        wr_xfer(7'h42, 0);
        start();
        mbusy = 1;
        send_byte(8'h85, 1'b1);
        wait_cyc(Q); sda_c = 1'b1;
        wait_cyc(Q); scl_c = 1'b1;
        wait_cyc(4);
        check("t6_driving", sda_w, 1);
        #2 rst_n = 1'b0;
        #1 check("t6_async_release", sda_w, 0);
        for (int i = 0; i < RC; i++) mdl[i] = 8'h00;
        mptr = 0; mbusy = 0; exp_q.delete();
        wait_cyc(4);
        check("t6_busy", busy, 0);
        rst_n = 1'b1;
        wait_cyc(Q);
        for (int i = 0; i < RC; i++) begin
            reg_addr = AW'(i); wait_cyc(2); check("t6_reg_zero", reg_rdata, 8'h00);
        end

        // randomized traffic
        for (int it = 0; it < 20; it++) begin
            int op;
            op = $urandom_range(0, 4);
            case (op)
                0: begin
                    txq = {8'($urandom)};
                    for (int j = 0; j < $urandom_range(1, 4); j++) txq.push_back(8'($urandom));
                    wr_xfer(7'h42, 1);
                end
                1: rd_xfer($urandom_range(1, 4));
                2: begin
                    for (int j = 0; j < $urandom_range(1, 3); j++)
                        local_wr($urandom_range(0, RC - 1), 8'($urandom));
                end
                3: begin
                    logic [6:0] a7;
                    a7 = 7'($urandom);
                    if (a7 == 7'h42) a7 = 7'h43;
                    txq = {8'($urandom), 8'($urandom)};
                    wr_xfer(a7, 1);
                end
                default: abort_xfer(8'($urandom), $urandom_range(1, 7));
            endcase
            check("rand_busy_idle", busy, 0);
            local_chk($urandom_range(0, RC - 1));
            local_chk($urandom_range(0, RC - 1));
        end

        dump_regs();
        check("wr_event_missing", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
